// File: rtl/ber_pkg.sv
// Shared definitions for the BER sync sweep sequencer.
// Holds the default sizing, where widths are derived from PRBS_LEN, and the
// FSM state encoding.
package ber_pkg;

    localparam int PRBS_LEN_DEF     = 511;
    localparam int ADDR_BITS_DEF    = $clog2(PRBS_LEN_DEF);
    localparam int ERR_WIN_BITS_DEF = $clog2(PRBS_LEN_DEF + 1);
    localparam int BER_CNT_BITS_DEF = 64;

    // Code 3 is unused and recovers to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_LOCK  = 2'd2
    } ber_state_e;

endpackage

// File: rtl/ber_sync_sweep_if.sv
// Handshake bundle between the BER phase controller, the reference PRBS
// delay line and the sweep sequencer.
//   i_ctrl              symbol strobe, one cycle per baud
//   i_start_synchro     sweep phase active
//   i_addr_done         current offset window complete (level, gated by i_ctrl)
//   i_start_ber_counter sweep finished, start lock-phase counting
//   i_rx_bit            hard-decision received bit
//   i_ref_bit           delay-line bit at o_ref_addr, same cycle
//   o_ref_addr          delay-line read offset
interface ber_sync_sweep_if #(
    parameter int ADDR_BITS = 9
) ();
    logic                 i_ctrl;
    logic                 i_start_synchro;
    logic                 i_addr_done;
    logic                 i_start_ber_counter;
    logic                 i_rx_bit;
    logic                 i_ref_bit;
    logic [ADDR_BITS-1:0] o_ref_addr;

    modport master (
        output i_ctrl, i_start_synchro, i_addr_done, i_start_ber_counter,
        output i_rx_bit, i_ref_bit,
        input  o_ref_addr
    );

    modport slave (
        input  i_ctrl, i_start_synchro, i_addr_done, i_start_ber_counter,
        input  i_rx_bit, i_ref_bit,
        output o_ref_addr
    );
endinterface

// File: rtl/ber_sat_counter.sv
// Saturating counter with a 1-bit increment.
//   clk      clock
//   i_clear  synchronous clear, highest priority
//   i_en     count enable
//   i_inc    increment value (0/1)
//   o_count  registered count; sticks at all-ones
module ber_sat_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_en && i_inc && !(&cnt_q))
            cnt_d = cnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (i_clear) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign o_count = cnt_q;
endmodule

// File: rtl/ber_sync_sweep.sv
// Receiver BER-tester sequencer. Sweeps every reference PRBS offset,
// counts mismatches per offset window, keeps the offset with the fewest
// errors, then locks the delay line to it and runs long-term bit/error
// counters.
//   clk, i_reset      clock, synchronous active-high reset
//   i_en_rx           receiver enable; low clears like reset
//   bus               controller flags, rx/ref bits, delay-line address
//   o_state           FSM state (0 idle, 1 sweep, 2 lock)
//   o_sync_done       high in lock
//   o_best_addr       offset with minimum window errors
//   o_min_errors      error count of that window
//   o_bit_count       bits compared in lock (saturating)
//   o_err_count       errors in lock (saturating)
module ber_sync_sweep
    import ber_pkg::*;
#(
    parameter int PRBS_LEN     = PRBS_LEN_DEF,
    parameter int ADDR_BITS    = ADDR_BITS_DEF,
    parameter int ERR_WIN_BITS = ERR_WIN_BITS_DEF,
    parameter int BER_CNT_BITS = BER_CNT_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    i_en_rx,
    ber_sync_sweep_if.slave         bus,
    output logic [1:0]              o_state,
    output logic                    o_sync_done,
    output logic [ADDR_BITS-1:0]    o_best_addr,
    output logic [ERR_WIN_BITS-1:0] o_min_errors,
    output logic [BER_CNT_BITS-1:0] o_bit_count,
    output logic [BER_CNT_BITS-1:0] o_err_count
);
    ber_state_e              state_q;
    logic [ADDR_BITS-1:0]    addr_q, best_q, addr_inc, next_best;
    logic [ERR_WIN_BITS-1:0] win_q, min_q, tot, mm_w;
    logic                    clr, mm, win_better, lock_en, sync_done_q;

    assign clr = i_reset | ~i_en_rx;

    always_comb begin
        mm         = bus.i_rx_bit ^ bus.i_ref_bit;
        mm_w       = ERR_WIN_BITS'(mm);
        tot        = (&win_q) ? win_q : win_q + mm_w;
        // Strict compare: ties keep the earlier offset.
        win_better = bus.i_addr_done && (tot < min_q);
        // Best offset including a window closing on this very strobe.
        next_best  = win_better ? addr_q : best_q;
        addr_inc   = (addr_q == ADDR_BITS'(PRBS_LEN - 1)) ? '0 : addr_q + ADDR_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            best_q      <= '0;
            min_q       <= '1;
            win_q       <= '0;
            sync_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The starting strobe already belongs to offset 0's window.
                    if (bus.i_ctrl && bus.i_start_synchro) begin
                        state_q <= ST_SWEEP;
                        win_q   <= mm_w;
                    end
                end
                ST_SWEEP: begin
                    if (bus.i_ctrl) begin
                        if (bus.i_addr_done) begin
                            if (win_better) begin
                                min_q  <= tot;
                                best_q <= addr_q;
                            end
                            win_q  <= '0;
                            addr_q <= addr_inc;
                        end else begin
                            win_q <= tot;
                        end
                        if (bus.i_start_ber_counter) begin
                            state_q     <= ST_LOCK;
                            sync_done_q <= 1'b1;
                            addr_q      <= next_best;
                        end
                    end
                end
                ST_LOCK: begin
                    // Address frozen; counting lives in the saturating counters.
                end
                default: begin
                    state_q     <= ST_IDLE;
                    addr_q      <= '0;
                    best_q      <= '0;
                    min_q       <= '1;
                    win_q       <= '0;
                    sync_done_q <= 1'b0;
                end
            endcase
        end
    end

    // The transition strobe is still seen in SWEEP, so its mismatch is not counted.
    assign lock_en = bus.i_ctrl && (state_q == ST_LOCK);

    ber_sat_counter #(.WIDTH(BER_CNT_BITS)) u_bit_cnt (
        .clk     (clk),
        .i_clear (clr),
        .i_en    (lock_en),
        .i_inc   (1'b1),
        .o_count (o_bit_count)
    );

    ber_sat_counter #(.WIDTH(BER_CNT_BITS)) u_err_cnt (
        .clk     (clk),
        .i_clear (clr),
        .i_en    (lock_en),
        .i_inc   (mm),
        .o_count (o_err_count)
    );

    assign bus.o_ref_addr = addr_q;
    assign o_state        = state_q;
    assign o_sync_done    = sync_done_q;
    assign o_best_addr    = best_q;
    assign o_min_errors   = min_q;
endmodule

// File: tb/tb_ber_sync_sweep.sv
// Bench for ber_sync_sweep at PRBS_LEN=31 (PRBS5 reference). A second
// instance with 4-bit lock counters sees the same stimulus to exercise
// saturation.
module tb_ber_sync_sweep;
    localparam int L  = 31;
    localparam int AB = 5;
    localparam int EB = 5;
    localparam int CB = 16;
    localparam int SB = 4;

    logic clk = 1'b0;
    logic rst, en;
    always #5 clk = ~clk;

    ber_sync_sweep_if #(.ADDR_BITS(AB)) bus ();
    ber_sync_sweep_if #(.ADDR_BITS(AB)) bus2 ();

    logic [1:0]    st, st2;
    logic          sd, sd2;
    logic [AB-1:0] best, best2;
    logic [EB-1:0] mn, mn2;
    logic [CB-1:0] bits, errc;
    logic [SB-1:0] bits2, errc2;

    ber_sync_sweep #(.PRBS_LEN(L), .ADDR_BITS(AB), .ERR_WIN_BITS(EB), .BER_CNT_BITS(CB)) dut (
        .clk(clk), .i_reset(rst), .i_en_rx(en), .bus(bus),
        .o_state(st), .o_sync_done(sd), .o_best_addr(best), .o_min_errors(mn),
        .o_bit_count(bits), .o_err_count(errc)
    );

    ber_sync_sweep #(.PRBS_LEN(L), .ADDR_BITS(AB), .ERR_WIN_BITS(EB), .BER_CNT_BITS(SB)) dut_sat (
        .clk(clk), .i_reset(rst), .i_en_rx(en), .bus(bus2),
        .o_state(st2), .o_sync_done(sd2), .o_best_addr(best2), .o_min_errors(mn2),
        .o_bit_count(bits2), .o_err_count(errc2)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   k = 0;          // strobe index into the PRBS stream
    logic p [L];
    int   errs [L];       // injected errors per window in tracking sweeps

    typedef struct {
        int rst, en, c, s, d, b, mm;
        int st, addr, best, mn, bits, errs;
    } vec_t;
    vec_t tv [15];

    function automatic logic p_at(input int kk, input int a);
        return p[((kk % L) - a + L) % L];
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(input logic c, s, d, b, rx, r1, r2);
        bus.i_ctrl = c;  bus.i_start_synchro = s;  bus.i_addr_done = d;
        bus.i_start_ber_counter = b;  bus.i_rx_bit = rx;  bus.i_ref_bit = r1;
        bus2.i_ctrl = c; bus2.i_start_synchro = s; bus2.i_addr_done = d;
        bus2.i_start_ber_counter = b; bus2.i_rx_bit = rx; bus2.i_ref_bit = r2;
        @(posedge clk);
        #1;
        if (c) k++;
    endtask

    // One strobe: rx is the PRBS at offset 'off' (optionally flipped), the
    // delay line answers at whatever address each DUT presents.
    task automatic strobe(input logic s, d, b, input int off, input logic flip);
        logic rx, r1, r2;
        rx = p_at(k, off) ^ flip;
        r1 = p_at(k, int'(bus.o_ref_addr));
        r2 = p_at(k, int'(bus2.o_ref_addr));
        drive(1'b1, s, d, b, rx, r1, r2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    // Strobes s0..s1-1 of a sweep; rx_fixed<0 makes rx track the bench's own
    // window index so only the injected errs[] show up as mismatches.
    task automatic sweep(input int rx_fixed, input int s0, input int s1, input bit sbc_last);
        for (int s = s0; s < s1; s++) begin
            int w, pos, off;
            w   = (s / L) % L;
            pos = s % L;
            off = (rx_fixed >= 0) ? rx_fixed : w;
            strobe(1'b1, pos == L - 1, sbc_last && (s == s1 - 1), off, pos < errs[w]);
        end
    endtask

    task automatic quick_lock();
        strobe(1'b1, 1'b0, 1'b0, 0, 1'b0);
        strobe(1'b1, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic lock_run(input int n, input int every, input bit gaps, input int off);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0)
                drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            strobe(1'b0, 1'b0, 1'b0, off, (i % every) == every - 1);
        end
    endtask

    initial begin
        p[0] = 1'b1;
        for (int n = 1; n < 5; n++) p[n] = 1'b0;
        for (int n = 5; n < L; n++) p[n] = p[n-3] ^ p[n-5];   // x^5+x^2+1
        for (int w = 0; w < L; w++) errs[w] = 0;

        //          rst en c  s  d  b  mm | st addr best mn bits errs
        tv[0]  = '{1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 31, 0, 0};
        tv[1]  = '{0, 1, 0, 1, 0, 0, 0,   0, 0, 0, 31, 0, 0};
        tv[2]  = '{0, 1, 1, 0, 0, 1, 0,   0, 0, 0, 31, 0, 0};
        tv[3]  = '{0, 1, 1, 1, 0, 0, 1,   1, 0, 0, 31, 0, 0};
        tv[4]  = '{0, 1, 1, 1, 1, 0, 1,   1, 1, 0, 2,  0, 0};
        tv[5]  = '{0, 1, 0, 1, 1, 0, 1,   1, 1, 0, 2,  0, 0};
        tv[6]  = '{0, 1, 1, 1, 0, 0, 0,   1, 1, 0, 2,  0, 0};
        tv[7]  = '{0, 1, 1, 1, 1, 0, 1,   1, 2, 1, 1,  0, 0};
        tv[8]  = '{0, 1, 1, 1, 0, 0, 1,   1, 2, 1, 1,  0, 0};
        tv[9]  = '{0, 1, 1, 1, 1, 0, 0,   1, 3, 1, 1,  0, 0};
        tv[10] = '{0, 1, 1, 1, 0, 1, 1,   2, 1, 1, 1,  0, 0};
        tv[11] = '{0, 1, 1, 1, 1, 0, 1,   2, 1, 1, 1,  1, 1};
        tv[12] = '{0, 1, 0, 0, 0, 0, 1,   2, 1, 1, 1,  1, 1};
        tv[13] = '{0, 1, 1, 0, 0, 0, 0,   2, 1, 1, 1,  2, 1};
        tv[14] = '{0, 0, 1, 1, 0, 0, 1,   0, 0, 0, 31, 0, 0};

        rst = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 15; i++) begin
            rst = (tv[i].rst != 0);
            en  = (tv[i].en != 0);
            drive(tv[i].c != 0, tv[i].s != 0, tv[i].d != 0, tv[i].b != 0,
                  tv[i].mm != 0, 1'b0, 1'b0);
            chk($sformatf("vec%0d_state", i), 64'(st),   64'(tv[i].st));
            chk($sformatf("vec%0d_addr", i),  64'(bus.o_ref_addr), 64'(tv[i].addr));
            chk($sformatf("vec%0d_best", i),  64'(best), 64'(tv[i].best));
            chk($sformatf("vec%0d_min", i),   64'(mn),   64'(tv[i].mn));
            chk($sformatf("vec%0d_bits", i),  64'(bits), 64'(tv[i].bits));
            chk($sformatf("vec%0d_errs", i),  64'(errc), 64'(tv[i].errs));
            chk($sformatf("vec%0d_sync", i),  64'(sd),   64'(tv[i].st == 2));
        end

        // Offset found: rx delayed so that offset 17 matches.
        do_reset();
        sweep(17, 0, L * L, 1'b0);
        strobe(1'b1, 1'b0, 1'b1, 17, 1'b0);
        chk("off_state", 64'(st), 64'd2);
        chk("off_sync",  64'(sd), 64'd1);
        chk("off_best",  64'(best), 64'd17);
        chk("off_min",   64'(mn), 64'd0);
        chk("off_addr",  64'(bus.o_ref_addr), 64'd17);
        chk("off_state_b", 64'(st2), 64'd2);
        chk("off_sync_b",  64'(sd2), 64'd1);
        chk("off_best_b",  64'(best2), 64'd17);
        chk("off_min_b",   64'(mn2), 64'd0);

        // Lock counting, 1 error per 100 strobes.
        lock_run(10000, 100, 1'b0, 17);
        chk("lock_bits", 64'(bits), 64'd10000);
        chk("lock_errs", 64'(errc), 64'd100);
        chk("lock_addr", 64'(bus.o_ref_addr), 64'd17);
        chk("lock_bits_sat", 64'(bits2), 64'd15);
        chk("lock_errs_sat", 64'(errc2), 64'd15);

        // Saturation with an all-error stream.
        do_reset();
        quick_lock();
        chk("sat_state", 64'(st), 64'd2);
        chk("sat_bits0", 64'(bits), 64'd0);
        lock_run(14, 1, 1'b0, 0);
        chk("sat_bits14", 64'(bits2), 64'd14);
        chk("sat_errs14", 64'(errc2), 64'd14);
        lock_run(1, 1, 1'b0, 0);
        chk("sat_bits15", 64'(bits2), 64'd15);
        chk("sat_errs15", 64'(errc2), 64'd15);
        lock_run(5, 1, 1'b0, 0);
        chk("sat_bits_hold", 64'(bits2), 64'd15);
        chk("sat_errs_hold", 64'(errc2), 64'd15);
        chk("sat_bits_wide", 64'(bits), 64'd20);
        chk("sat_errs_wide", 64'(errc), 64'd20);

        // Lock counting with random strobe gaps.
        do_reset();
        quick_lock();
        lock_run(10000, 100, 1'b1, 0);
        chk("gap_bits", 64'(bits), 64'd10000);
        chk("gap_errs", 64'(errc), 64'd100);

        // Tie: offsets 12 and 20 both 3 errors, others 5.
        do_reset();
        for (int w = 0; w < L; w++) errs[w] = 5;
        errs[12] = 3;
        errs[20] = 3;
        sweep(-1, 0, L * L, 1'b0);
        strobe(1'b1, 1'b0, 1'b1, 0, 1'b0);
        chk("tie_best", 64'(best), 64'd12);
        chk("tie_min",  64'(mn), 64'd3);
        chk("tie_addr", 64'(bus.o_ref_addr), 64'd12);

        // Mid-sweep clear at offset 25, then restart.
        do_reset();
        for (int w = 0; w < L; w++) errs[w] = 0;
        sweep(17, 0, 25 * L + 10, 1'b0);
        chk("mid_addr_pre", 64'(bus.o_ref_addr), 64'd25);
        chk("mid_best_pre", 64'(best), 64'd17);
        en = 1'b0;
        strobe(1'b1, 1'b1, 1'b1, 17, 1'b0);
        en = 1'b1;
        chk("mid_state", 64'(st), 64'd0);
        chk("mid_addr",  64'(bus.o_ref_addr), 64'd0);
        chk("mid_min",   64'(mn), 64'd31);
        chk("mid_best",  64'(best), 64'd0);
        chk("mid_bits",  64'(bits), 64'd0);
        chk("mid_errs",  64'(errc), 64'd0);
        sweep(17, 0, L * L, 1'b0);
        strobe(1'b1, 1'b0, 1'b1, 17, 1'b0);
        chk("restart_best", 64'(best), 64'd17);
        chk("restart_min",  64'(mn), 64'd0);
        chk("restart_addr", 64'(bus.o_ref_addr), 64'd17);

        // Window close and lock on the same strobe; all-ones windows never win.
        do_reset();
        for (int w = 0; w < L; w++) errs[w] = 31;
        errs[30] = 2;
        sweep(-1, 0, L, 1'b0);
        chk("sim_min_w0",  64'(mn), 64'd31);
        chk("sim_best_w0", 64'(best), 64'd0);
        chk("sim_addr_w0", 64'(bus.o_ref_addr), 64'd1);
        sweep(-1, L, L * L, 1'b1);
        chk("sim_state", 64'(st), 64'd2);
        chk("sim_addr",  64'(bus.o_ref_addr), 64'd30);
        chk("sim_best",  64'(best), 64'd30);
        chk("sim_min",   64'(mn), 64'd2);
        chk("sim_sync",  64'(sd), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
